// File: rtl/mem_wb_responder_pkg.sv
// Shared encodings for the memory/writeback responder: result-select codes,
// the default halt register address and the halt FSM state type.
package mem_wb_responder_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [31:0] DEFAULT_HALT_ADDR = 32'hFFFF_FFF0;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } haltState_t;

    function automatic logic isWordAligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_responder_if.sv
// Memory-stage inputs and writeback-stage outputs between the datapath
// (master) and the memory/writeback responder (slave).
interface mem_wb_responder_if;

    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        MemWriteM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;

    logic [31:0] ResultW;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic        Halted;
    logic [31:0] HaltCode;
    logic        MisalignErr;

    modport master (
        output ALUResultM, WriteDataM, MemWriteM, RegWriteM, ResultSrcM, RdM, PCPlus4M,
        input  ResultW, RdW, RegWriteW, Halted, HaltCode, MisalignErr
    );

    modport slave (
        input  ALUResultM, WriteDataM, MemWriteM, RegWriteM, ResultSrcM, RdM, PCPlus4M,
        output ResultW, RdW, RegWriteW, Halted, HaltCode, MisalignErr
    );

endinterface

// File: rtl/mem_wb_responder_dmem_array.sv
// Word-addressed data RAM: combinational read, write on the rising clock edge.
// Contents are deliberately not reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];

    assign rdata_o = mem[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/mem_wb_responder.sv
// Memory stage plus writeback register for the pipelined RV32 core, with a
// memory-mapped halt register and sticky misalignment flag for end-of-test.
module mem_wb_responder
    import mem_wb_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] HALT_ADDR   = DEFAULT_HALT_ADDR
) (
    input  logic           clk,
    input  logic           reset,
    mem_wb_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic          aligned;
    logic          inRange;
    logic          isHaltAddr;
    logic          isLoad;
    logic          memWe;
    logic [AW-1:0] wordIdx;
    logic [31:0]   memRdata;
    logic [31:0]   loadData;

    haltState_t    state_q, state_d;
    logic [31:0]   haltCode_q, haltCode_d;
    logic          misalign_q, misalign_d;

    logic          regWriteW_q;
    logic [1:0]    resultSrcW_q;
    logic [4:0]    rdW_q;
    logic [31:0]   aluResultW_q;
    logic [31:0]   readDataW_q;
    logic [31:0]   pcPlus4W_q;

    assign wordIdx    = bus.ALUResultM[AW+1:2];
    assign aligned    = isWordAligned(bus.ALUResultM);
    assign inRange    = (bus.ALUResultM[31:AW+2] == '0);
    assign isHaltAddr = (bus.ALUResultM == HALT_ADDR);
    assign isLoad     = (bus.ResultSrcM == RES_MEM);

    // Reset gating keeps a store that lands on the reset edge from committing.
    assign memWe    = bus.MemWriteM && aligned && inRange && (state_q == RUN) && !reset;
    assign loadData = (aligned && inRange) ? memRdata : 32'd0;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_dmem (
        .clk     (clk),
        .we_i    (memWe),
        .addr_i  (wordIdx),
        .wdata_i (bus.WriteDataM),
        .rdata_o (memRdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            haltCode_q <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            haltCode_q <= haltCode_d;
            misalign_q <= misalign_d;
        end
    end

    // HALTED is terminal until reset; the first halt store's data is kept.
    always_comb begin
        state_d    = state_q;
        haltCode_d = haltCode_q;
        misalign_d = misalign_q;
        if ((state_q == RUN) && bus.MemWriteM && isHaltAddr) begin
            state_d    = HALTED;
            haltCode_d = bus.WriteDataM;
        end
        if ((bus.MemWriteM || isLoad) && !aligned) begin
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regWriteW_q  <= 1'b0;
            resultSrcW_q <= RES_ALU;
            rdW_q        <= 5'd0;
            aluResultW_q <= 32'd0;
            readDataW_q  <= 32'd0;
            pcPlus4W_q   <= 32'd0;
        end else begin
            regWriteW_q  <= bus.RegWriteM;
            resultSrcW_q <= bus.ResultSrcM;
            rdW_q        <= bus.RdM;
            aluResultW_q <= bus.ALUResultM;
            readDataW_q  <= loadData;
            pcPlus4W_q   <= bus.PCPlus4M;
        end
    end

    always_comb begin
        bus.ResultW = 32'd0;
        case (resultSrcW_q)
            RES_ALU: bus.ResultW = aluResultW_q;
            RES_MEM: bus.ResultW = readDataW_q;
            RES_PC4: bus.ResultW = pcPlus4W_q;
            default: bus.ResultW = 32'd0;
        endcase
    end

    assign bus.RdW         = rdW_q;
    assign bus.RegWriteW   = regWriteW_q && (rdW_q != 5'd0);
    assign bus.Halted      = (state_q == HALTED);
    assign bus.HaltCode    = haltCode_q;
    assign bus.MisalignErr = misalign_q;

endmodule

// File: tb/tb_mem_wb_responder.sv
// Directed testbench for mem_wb_responder: each task drives one scenario and
// compares the writeback/status outputs against hand-computed values.
module tb_mem_wb_responder;
    import mem_wb_responder_pkg::*;

    logic clk;
    logic reset;
    int   testsRun;
    int   testsFailed;

    mem_wb_responder_if bus ();

    mem_wb_responder #(
        .DEPTH_WORDS (256),
        .HALT_ADDR   (32'hFFFF_FFF0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one instruction into M, then returns just after the edge so its W outputs are visible.
    task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] wdata,
                                 input logic memWrite, input logic regWrite,
                                 input logic [1:0] src, input logic [4:0] rd,
                                 input logic [31:0] pc4);
        bus.ALUResultM = alu;
        bus.WriteDataM = wdata;
        bus.MemWriteM  = memWrite;
        bus.RegWriteM  = regWrite;
        bus.ResultSrcM = src;
        bus.RdM        = rd;
        bus.PCPlus4M   = pc4;
        @(posedge clk);
        #1;
    endtask

    task automatic applyNop();
        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, RES_ALU, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.ALUResultM = 32'd0;
        bus.WriteDataM = 32'd0;
        bus.MemWriteM  = 1'b0;
        bus.RegWriteM  = 1'b0;
        bus.ResultSrcM = RES_ALU;
        bus.RdM        = 5'd0;
        bus.PCPlus4M   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        testsRun++;
        if (bus.ResultW !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset.ResultW got %h expected %h", bus.ResultW, 32'd0); end
        testsRun++;
        if (bus.RdW !== 5'd0) begin testsFailed++; $display("[TB] FAIL reset.RdW got %0d expected 0", bus.RdW); end
        testsRun++;
        if (bus.RegWriteW !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset.RegWriteW got %b expected 0", bus.RegWriteW); end
        testsRun++;
        if (bus.Halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset.Halted got %b expected 0", bus.Halted); end
        testsRun++;
        if (bus.HaltCode !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset.HaltCode got %h expected 0", bus.HaltCode); end
        testsRun++;
        if (bus.MisalignErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset.MisalignErr got %b expected 0", bus.MisalignErr); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        applyStimulus(32'h10, 32'hDEADBEEF, 1'b1, 1'b0, RES_ALU, 5'd0, 32'h4);
        applyStimulus(32'h10, 32'h0, 1'b0, 1'b1, RES_MEM, 5'd5, 32'h8);
        testsRun++;
        if (bus.ResultW !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL storeLoad.ResultW got %h expected %h", bus.ResultW, 32'hDEADBEEF); end
        testsRun++;
        if (bus.RdW !== 5'd5) begin testsFailed++; $display("[TB] FAIL storeLoad.RdW got %0d expected 5", bus.RdW); end
        testsRun++;
        if (bus.RegWriteW !== 1'b1) begin testsFailed++; $display("[TB] FAIL storeLoad.RegWriteW got %b expected 1", bus.RegWriteW); end
    endtask

    task automatic test_result_mux();
        applyStimulus(32'h1234, 32'h0, 1'b0, 1'b1, RES_ALU, 5'd0, 32'h40);
        testsRun++;
        if (bus.ResultW !== 32'h1234) begin testsFailed++; $display("[TB] FAIL aluX0.ResultW got %h expected %h", bus.ResultW, 32'h1234); end
        testsRun++;
        if (bus.RegWriteW !== 1'b0) begin testsFailed++; $display("[TB] FAIL aluX0.RegWriteW got %b expected 0", bus.RegWriteW); end

        applyStimulus(32'h55, 32'h0, 1'b0, 1'b1, RES_PC4, 5'd1, 32'h80);
        testsRun++;
        if (bus.ResultW !== 32'h80) begin testsFailed++; $display("[TB] FAIL jal.ResultW got %h expected %h", bus.ResultW, 32'h80); end
        testsRun++;
        if (bus.RdW !== 5'd1) begin testsFailed++; $display("[TB] FAIL jal.RdW got %0d expected 1", bus.RdW); end
        testsRun++;
        if (bus.RegWriteW !== 1'b1) begin testsFailed++; $display("[TB] FAIL jal.RegWriteW got %b expected 1", bus.RegWriteW); end

        applyStimulus(32'h77, 32'h0, 1'b0, 1'b1, 2'b11, 5'd2, 32'h90);
        testsRun++;
        if (bus.ResultW !== 32'd0) begin testsFailed++; $display("[TB] FAIL reservedSrc.ResultW got %h expected 0", bus.ResultW); end

        applyStimulus(32'h1000, 32'h0, 1'b0, 1'b1, RES_MEM, 5'd7, 32'h94);
        testsRun++;
        if (bus.ResultW !== 32'd0) begin testsFailed++; $display("[TB] FAIL oorLoad.ResultW got %h expected 0", bus.ResultW); end
        testsRun++;
        if (bus.MisalignErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL oorLoad.MisalignErr got %b expected 0", bus.MisalignErr); end
    endtask

    task automatic test_misalign();
        applyStimulus(32'h13, 32'h11111111, 1'b1, 1'b0, RES_ALU, 5'd0, 32'h0);
        testsRun++;
        if (bus.MisalignErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL misStore.MisalignErr got %b expected 1", bus.MisalignErr); end
        applyStimulus(32'h10, 32'h0, 1'b0, 1'b1, RES_MEM, 5'd6, 32'h0);
        testsRun++;
        if (bus.ResultW !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL misStore.word4 got %h expected %h", bus.ResultW, 32'hDEADBEEF); end
        for (int i = 0; i < 10; i++) applyNop();
        testsRun++;
        if (bus.MisalignErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL misStore.sticky got %b expected 1", bus.MisalignErr); end
    endtask

    task automatic test_halt();
        applyStimulus(32'h20, 32'h0000CAFE, 1'b1, 1'b0, RES_ALU, 5'd0, 32'h0);
        applyStimulus(32'h40, 32'h12345678, 1'b1, 1'b0, RES_ALU, 5'd0, 32'h0);
        testsRun++;
        if (bus.Halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL preHalt.Halted got %b expected 0", bus.Halted); end
        applyStimulus(32'hFFFF_FFF0, 32'd42, 1'b1, 1'b0, RES_ALU, 5'd0, 32'h0);
        testsRun++;
        if (bus.Halted !== 1'b1) begin testsFailed++; $display("[TB] FAIL halt.Halted got %b expected 1", bus.Halted); end
        testsRun++;
        if (bus.HaltCode !== 32'd42) begin testsFailed++; $display("[TB] FAIL halt.HaltCode got %h expected %h", bus.HaltCode, 32'd42); end
        applyStimulus(32'h20, 32'd7, 1'b1, 1'b0, RES_ALU, 5'd0, 32'h0);
        applyStimulus(32'hFFFF_FFF0, 32'd99, 1'b1, 1'b0, RES_ALU, 5'd0, 32'h0);
        applyStimulus(32'h20, 32'h0, 1'b0, 1'b1, RES_MEM, 5'd3, 32'h0);
        testsRun++;
        if (bus.ResultW !== 32'h0000CAFE) begin testsFailed++; $display("[TB] FAIL halted.loadResult got %h expected %h", bus.ResultW, 32'h0000CAFE); end
        testsRun++;
        if (bus.RegWriteW !== 1'b1 || bus.RdW !== 5'd3) begin testsFailed++; $display("[TB] FAIL halted.retire got we=%b rd=%0d expected we=1 rd=3", bus.RegWriteW, bus.RdW); end
        testsRun++;
        if (bus.HaltCode !== 32'd42) begin testsFailed++; $display("[TB] FAIL halted.HaltCodeKept got %h expected %h", bus.HaltCode, 32'd42); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        bus.ALUResultM = 32'h40;
        bus.WriteDataM = 32'h00000BAD;
        bus.MemWriteM  = 1'b1;
        bus.RegWriteM  = 1'b0;
        bus.ResultSrcM = RES_ALU;
        bus.RdM        = 5'd0;
        reset = 1'b1;
        #1;
        testsRun++;
        if (bus.ResultW !== 32'd0 || bus.RdW !== 5'd0 || bus.RegWriteW !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midReset.W got %h/%0d/%b expected 0/0/0", bus.ResultW, bus.RdW, bus.RegWriteW);
        end
        testsRun++;
        if (bus.Halted !== 1'b0 || bus.HaltCode !== 32'd0 || bus.MisalignErr !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midReset.status got %b/%h/%b expected 0/0/0", bus.Halted, bus.HaltCode, bus.MisalignErr);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(32'h40, 32'h0, 1'b0, 1'b1, RES_MEM, 5'd4, 32'h0);
        testsRun++;
        if (bus.ResultW !== 32'h12345678) begin testsFailed++; $display("[TB] FAIL midReset.word40 got %h expected %h", bus.ResultW, 32'h12345678); end
        applyStimulus(32'h22, 32'h0, 1'b0, 1'b1, RES_MEM, 5'd6, 32'h0);
        testsRun++;
        if (bus.ResultW !== 32'd0 || bus.MisalignErr !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL misLoad got %h/%b expected 0/1", bus.ResultW, bus.MisalignErr);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_back_to_back();
        test_result_mux();
        test_misalign();
        test_halt();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
